// File: rtl/regfile_scan_ctrl.sv
// Debug/boot-time register-file scan controller: dumps a wrap-around register range
// over a valid/ready stream, or loads a stream into that range, while stalling the CPU.
module regfile_scan_ctrl #(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] first_reg,
   input  logic [ADDR_W-1:0] last_reg,
   input  logic              abort,
   output logic              busy,
   output logic              cpu_stall,
   output logic              done,
   output logic [ADDR_W-1:0] reg_source_1,
   input  logic [XLEN-1:0]   read_data_1,
   output logic [ADDR_W-1:0] reg_destination,
   output logic [XLEN-1:0]   Write_data,
   output logic              reg_write_en,
   output logic [XLEN-1:0]   dump_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   input  logic [XLEN-1:0]   load_data,
   input  logic              load_valid,
   output logic              load_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_SEND,
      S_LD_WAIT,
      S_LD_WRITE,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_idx;
   logic [ADDR_W-1:0]   r_last;
   logic [ADDR_W-1:0]   r_src;
   logic [ADDR_W-1:0]   r_dst;
   logic [XLEN-1:0]     r_dump;
   logic [XLEN-1:0]     r_wdata;
   logic                r_busy;
   logic                r_done;
   logic                r_dvalid;
   logic                r_lready;
   logic                r_we;
   logic                w_last_hit;
   logic [ADDR_W-1:0]   w_idx_inc;

   assign w_last_hit = (r_idx == r_last);
   assign w_idx_inc  = r_idx + ADDR_W'(1);

   // Abort overrides every transition, including a same-cycle handshake.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:     if (start) w_state_next = mode ? S_LD_WAIT : S_RD_ADDR;
         S_RD_ADDR:  w_state_next = S_RD_SEND;
         S_RD_SEND:  if (dump_ready) w_state_next = w_last_hit ? S_DONE : S_RD_ADDR;
         S_LD_WAIT:  if (load_valid) w_state_next = S_LD_WRITE;
         S_LD_WRITE: w_state_next = w_last_hit ? S_DONE : S_LD_WAIT;
         S_DONE:     w_state_next = S_IDLE;
         default:    w_state_next = S_IDLE;
      endcase
      if (abort && (r_state != S_IDLE)) w_state_next = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_last   <= '0;
         r_src    <= '0;
         r_dst    <= '0;
         r_dump   <= '0;
         r_wdata  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dvalid <= 1'b0;
         r_lready <= 1'b0;
         r_we     <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_busy   <= (w_state_next != S_IDLE);
         r_done   <= (w_state_next == S_DONE);
         r_dvalid <= (w_state_next == S_RD_SEND);
         r_lready <= (w_state_next == S_LD_WAIT);
         // x0 is hardwired: its word is consumed but never written.
         r_we     <= (w_state_next == S_LD_WRITE) && (r_idx != '0);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_idx  <= first_reg;
                  r_last <= last_reg;
                  if (!mode) r_src <= first_reg;
               end
            end
            S_RD_ADDR: r_dump <= read_data_1;
            S_RD_SEND: begin
               if (w_state_next == S_RD_ADDR) begin
                  r_idx <= w_idx_inc;
                  r_src <= w_idx_inc;
               end
            end
            S_LD_WAIT: begin
               if (w_state_next == S_LD_WRITE) begin
                  r_dst   <= r_idx;
                  r_wdata <= load_data;
               end
            end
            S_LD_WRITE: if (w_state_next == S_LD_WAIT) r_idx <= w_idx_inc;
            default: ;
         endcase
      end
   end

   assign busy            = r_busy;
   assign cpu_stall       = r_busy;
   assign done            = r_done;
   assign reg_source_1    = r_src;
   assign reg_destination = r_dst;
   assign Write_data      = r_wdata;
   assign reg_write_en    = r_we;
   assign dump_data       = r_dump;
   assign dump_valid      = r_dvalid;
   assign load_ready      = r_lready;

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// Bench for regfile_scan_ctrl: a behavioural register file plus a range/word model
// checks dump streams, load writes, timing, abort and reset behaviour.
module tb_regfile_scan_ctrl;
   localparam int XLEN = 64;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            mode = 1'b0;
   logic [AW-1:0]   first_reg = '0;
   logic [AW-1:0]   last_reg = '0;
   logic            abort = 1'b0;
   logic            dump_ready = 1'b0;
   logic [XLEN-1:0] load_data = '0;
   logic            load_valid = 1'b0;
   logic            busy, cpu_stall, done, reg_write_en, dump_valid, load_ready;
   logic [AW-1:0]   reg_source_1, reg_destination;
   logic [XLEN-1:0] read_data_1, Write_data, dump_data;

   always #5 clk = ~clk;

   regfile_scan_ctrl #(.XLEN(XLEN), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .first_reg(first_reg), .last_reg(last_reg), .abort(abort),
      .busy(busy), .cpu_stall(cpu_stall), .done(done),
      .reg_source_1(reg_source_1), .read_data_1(read_data_1),
      .reg_destination(reg_destination), .Write_data(Write_data),
      .reg_write_en(reg_write_en), .dump_data(dump_data),
      .dump_valid(dump_valid), .dump_ready(dump_ready),
      .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready)
   );

   // CPU register file stand-in with a backdoor preload port.
   logic [XLEN-1:0] rf [32];
   logic            pl_en = 1'b0;
   logic [AW-1:0]   pl_addr = '0;
   logic [XLEN-1:0] pl_data = '0;
   always @(posedge clk) begin
      if (pl_en) rf[pl_addr] <= pl_data;
      else if (reg_write_en) rf[reg_destination] <= Write_data;
   end
   assign read_data_1 = (reg_source_1 == '0) ? '0 : rf[reg_source_1];

   typedef struct { int t; logic [AW-1:0] a; logic [XLEN-1:0] d; } wr_t;

   logic [XLEN-1:0] exp_rf [32];
   logic [XLEN-1:0] words[$];
   logic [XLEN-1:0] got_q[$];
   logic [XLEN-1:0] exp_q[$];
   int              exp_idx[$];
   int              hs_t[$];
   wr_t             wlog[$];
   wr_t             exp_wr[$];
   logic            lr_tr[$];
   int              done_n, done_t, dv_first_t, end_t, abort_t;
   logic            busy0, stall0, busy_after, dv_after;
   logic [AW-1:0]   src0;
   int              vectors = 0;
   int              miscompares = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [XLEN-1:0] model_read(int i);
      return (i == 0) ? '0 : exp_rf[i];
   endfunction

   // Indices visited: first, first+1, ... mod 32, stopping after last.
   function automatic void build_range(int f, int l);
      int i;
      exp_idx.delete();
      exp_q.delete();
      i = f;
      for (int n = 0; n < 32; n++) begin
         exp_idx.push_back(i);
         exp_q.push_back(model_read(i));
         if (i == l) break;
         i = (i + 1) % 32;
      end
   endfunction

   // Each accepted word lands at its index one cycle after its handshake, except x0.
   function automatic void apply_load_model(int nhs);
      exp_wr.delete();
      for (int i = 0; i < nhs && i < exp_idx.size() && i < words.size(); i++) begin
         if (exp_idx[i] != 0) begin
            exp_rf[exp_idx[i]] = words[i];
            exp_wr.push_back('{hs_t[i] + 1, AW'(exp_idx[i]), words[i]});
         end
      end
   endfunction

   function automatic void random_words(int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom});
   endfunction

   task automatic preload(input int a, input logic [XLEN-1:0] d);
      pl_en = 1'b1;
      pl_addr = AW'(a);
      pl_data = d;
      tick();
      pl_en = 1'b0;
      exp_rf[a] = d;
   endtask

   // Runs one operation; t=0 is the first cycle after the start edge.
   task automatic run_op(input logic m, input int f, input int l, input int prob,
                         input int abort_hs, input bit noisy);
      int  k, hs_n;
      bit  finished, acc;
      got_q.delete(); hs_t.delete(); wlog.delete(); lr_tr.delete();
      done_n = 0; done_t = -1; dv_first_t = -1; end_t = -1; abort_t = -1;
      busy_after = 1'bx; dv_after = 1'bx;
      k = 0; hs_n = 0; finished = 0;
      mode = m; first_reg = AW'(f); last_reg = AW'(l); start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < 2000; t++) begin
         if (t == 0) begin busy0 = busy; stall0 = cpu_stall; src0 = reg_source_1; end
         if (abort_t >= 0 && t == abort_t + 1) begin busy_after = busy; dv_after = dump_valid; end
         if (!busy) begin finished = 1; end_t = t; break; end
         if (done) begin done_n++; done_t = t; end
         if (dump_valid && dv_first_t < 0) dv_first_t = t;
         if (reg_write_en) wlog.push_back('{t, reg_destination, Write_data});
         lr_tr.push_back(load_ready);
         acc = m ? load_ready : dump_valid;
         load_data = (k < words.size()) ? words[k] : {$urandom, $urandom};
         if (abort_hs >= 0 && hs_n == abort_hs && acc && abort_t < 0) begin
            abort = 1'b1; abort_t = t; dump_ready = 1'b1; load_valid = 1'b1;
         end else begin
            dump_ready = ($urandom_range(99) < prob);
            load_valid = (k < words.size()) && ($urandom_range(99) < prob);
            if (!m && dump_valid && dump_ready) begin
               got_q.push_back(dump_data); hs_t.push_back(t); hs_n++;
            end
            if (m && load_valid && load_ready) begin
               hs_t.push_back(t); hs_n++; k++;
            end
         end
         if (noisy) begin
            start = 1'($urandom_range(1)); mode = 1'($urandom_range(1));
            first_reg = AW'($urandom_range(31)); last_reg = AW'($urandom_range(31));
         end
         tick();
         abort = 1'b0;
      end
      start = 1'b0; dump_ready = 1'b0; load_valid = 1'b0; abort = 1'b0;
      vectors++;
      if (!finished) begin
         miscompares++;
         $display("FAIL op_timeout: busy still %b after 2000 cycles, expected 0", busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      vectors++;
      if ({busy, cpu_stall, done, dump_valid, load_ready, reg_write_en} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {busy, cpu_stall, done, dump_valid, load_ready, reg_write_en});
      end
      vectors++;
      if (dump_data !== '0 || Write_data !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got dump=%h wdata=%h expected 0", dump_data, Write_data);
      end
      vectors++;
      if (reg_source_1 !== '0 || reg_destination !== '0) begin
         miscompares++;
         $display("FAIL reset_index: got src=%0d dst=%0d expected 0", reg_source_1, reg_destination);
      end
      for (int i = 0; i < 32; i++) preload(i, {$urandom, $urandom});
   endtask

   task automatic test_dump_wrap();
      preload(30, 64'hAA); preload(31, 64'hBB); preload(1, 64'h11);
      build_range(30, 1);
      run_op(1'b0, 30, 1, 100, -1, 0);
      vectors++;
      if (got_q.size() != 4) begin
         miscompares++; $display("FAIL wrap_count: got %0d words expected 4", got_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL wrap_word[%0d]: got %h expected %h", i,
                     (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
         end
      end
      vectors++;
      if (busy0 !== 1'b1 || stall0 !== 1'b1 || src0 !== 5'd30) begin
         miscompares++;
         $display("FAIL wrap_cycle1: got busy=%b stall=%b src=%0d expected 1 1 30", busy0, stall0, src0);
      end
      vectors++;
      if (dv_first_t != 1) begin
         miscompares++; $display("FAIL wrap_valid_latency: got t=%0d expected 1", dv_first_t);
      end
      for (int i = 1; i < hs_t.size(); i++) begin
         vectors++;
         if (hs_t[i] - hs_t[i-1] != 2) begin
            miscompares++; $display("FAIL wrap_throughput: got gap %0d expected 2", hs_t[i] - hs_t[i-1]);
         end
      end
      vectors++;
      if (done_n != 1 || hs_t.size() == 0 || done_t != hs_t[hs_t.size()-1] + 1 || end_t != done_t + 1) begin
         miscompares++;
         $display("FAIL wrap_done: got count=%0d t=%0d end=%0d expected 1 pulse right after last handshake",
                  done_n, done_t, end_t);
      end
   endtask

   task automatic test_dump_backpressure();
      preload(5, 64'h1234);
      mode = 1'b0; first_reg = 5'd5; last_reg = 5'd5; dump_ready = 1'b0; start = 1'b1;
      tick(); start = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (dump_valid !== 1'b1 || dump_data !== 64'h1234 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: got valid=%b data=%h done=%b expected 1 1234 0",
                     i, dump_valid, dump_data, done);
         end
         tick();
      end
      dump_ready = 1'b1;
      tick();
      dump_ready = 1'b0;
      vectors++;
      if (done !== 1'b1 || dump_valid !== 1'b0) begin
         miscompares++; $display("FAIL bp_done: got done=%b valid=%b expected 1 0", done, dump_valid);
      end
      tick();
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++; $display("FAIL bp_idle: got busy=%b expected 0", busy);
      end
   endtask

   task automatic test_load_range();
      words.delete();
      words.push_back(64'hA); words.push_back(64'hB); words.push_back(64'hC); words.push_back(64'hD);
      build_range(0, 3);
      run_op(1'b1, 0, 3, 100, -1, 0);
      apply_load_model(hs_t.size());
      vectors++;
      if (hs_t.size() != 4 || wlog.size() != 3) begin
         miscompares++;
         $display("FAIL load_counts: got %0d words %0d strobes expected 4 3", hs_t.size(), wlog.size());
      end
      for (int j = 0; j < exp_wr.size() && j < wlog.size(); j++) begin
         vectors++;
         if (wlog[j].t != exp_wr[j].t || wlog[j].a !== exp_wr[j].a || wlog[j].d !== exp_wr[j].d) begin
            miscompares++;
            $display("FAIL load_write[%0d]: got t=%0d x%0d=%h expected t=%0d x%0d=%h", j,
                     wlog[j].t, wlog[j].a, wlog[j].d, exp_wr[j].t, exp_wr[j].a, exp_wr[j].d);
         end
      end
      for (int i = 1; i < 4; i++) begin
         vectors++;
         if (rf[i] !== exp_rf[i]) begin
            miscompares++; $display("FAIL load_reg x%0d: got %h expected %h", i, rf[i], exp_rf[i]);
         end
      end
      vectors++;
      if (hs_t.size() < 2 || lr_tr[hs_t[0]+1] !== 1'b0 || lr_tr[hs_t[0]+2] !== 1'b1) begin
         miscompares++; $display("FAIL load_ready_timing: got ready drop/return wrong, expected 0 then 1");
      end
      vectors++;
      if (done_n != 1 || hs_t.size() != 4 || done_t != hs_t[3] + 2) begin
         miscompares++; $display("FAIL load_done: got count=%0d t=%0d expected 1 at t=8", done_n, done_t);
      end
   endtask

   task automatic test_full_sweep();
      random_words(32);
      build_range(1, 0);
      run_op(1'b1, 1, 0, 60, -1, 1);
      apply_load_model(hs_t.size());
      vectors++;
      if (hs_t.size() != 32 || wlog.size() != 31 || done_n != 1) begin
         miscompares++;
         $display("FAIL sweep_counts: got %0d words %0d strobes %0d done expected 32 31 1",
                  hs_t.size(), wlog.size(), done_n);
      end
      for (int j = 0; j < exp_wr.size() && j < wlog.size(); j++) begin
         if (wlog[j].t != exp_wr[j].t || wlog[j].a !== exp_wr[j].a || wlog[j].d !== exp_wr[j].d) begin
            vectors++; miscompares++;
            $display("FAIL sweep_write[%0d]: got t=%0d x%0d expected t=%0d x%0d", j,
                     wlog[j].t, wlog[j].a, exp_wr[j].t, exp_wr[j].a);
         end
      end
      for (int i = 1; i < 32; i++) begin
         vectors++;
         if (rf[i] !== exp_rf[i]) begin
            miscompares++; $display("FAIL sweep_reg x%0d: got %h expected %h", i, rf[i], exp_rf[i]);
         end
      end
   endtask

   task automatic test_abort();
      random_words(7);
      build_range(4, 10);
      run_op(1'b1, 4, 10, 100, 2, 0);
      apply_load_model(hs_t.size());
      vectors++;
      if (hs_t.size() != 2 || wlog.size() != 2 || done_n != 0 || busy_after !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_load: got %0d words %0d writes %0d done busy=%b expected 2 2 0 0",
                  hs_t.size(), wlog.size(), done_n, busy_after);
      end
      for (int i = 4; i <= 10; i++) begin
         vectors++;
         if (rf[i] !== exp_rf[i]) begin
            miscompares++; $display("FAIL abort_reg x%0d: got %h expected %h", i, rf[i], exp_rf[i]);
         end
      end
      build_range(7, 9);
      run_op(1'b0, 7, 9, 0, 0, 0);
      vectors++;
      if (abort_t < 0 || got_q.size() != 0 || done_n != 0 || busy_after !== 1'b0 || dv_after !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_dump: got words=%0d done=%0d busy=%b valid=%b expected 0 0 0 0",
                  got_q.size(), done_n, busy_after, dv_after);
      end
   endtask

   task automatic test_reset_mid_dump();
      mode = 1'b0; first_reg = 5'd2; last_reg = 5'd6; dump_ready = 1'b0; start = 1'b1;
      tick(); start = 1'b0; tick();
      vectors++;
      if (dump_valid !== 1'b1) begin
         miscompares++; $display("FAIL rstmid_pre: got valid=%b expected 1", dump_valid);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      vectors++;
      if ({busy, cpu_stall, done, dump_valid, load_ready, reg_write_en} !== 6'b0 ||
          dump_data !== '0 || Write_data !== '0 || reg_source_1 !== '0 || reg_destination !== '0) begin
         miscompares++;
         $display("FAIL rstmid_values: got flags=%b dump=%h src=%0d expected all 0",
                  {busy, cpu_stall, done, dump_valid, load_ready, reg_write_en}, dump_data, reg_source_1);
      end
      first_reg = 5'd9; last_reg = 5'd9; start = 1'b1;
      tick(); start = 1'b0;
      vectors++;
      if (busy !== 1'b1 || reg_source_1 !== 5'd9) begin
         miscompares++; $display("FAIL rstmid_restart: got busy=%b src=%0d expected 1 9", busy, reg_source_1);
      end
      tick();
      vectors++;
      if (dump_valid !== 1'b1 || dump_data !== model_read(9)) begin
         miscompares++;
         $display("FAIL rstmid_data: got valid=%b data=%h expected 1 %h", dump_valid, dump_data, model_read(9));
      end
      dump_ready = 1'b1; tick(); dump_ready = 1'b0;
      vectors++;
      if (done !== 1'b1) begin
         miscompares++; $display("FAIL rstmid_done: got %b expected 1", done);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      build_range(12, 13);
      run_op(1'b0, 12, 13, 100, -1, 0);
      vectors++;
      if (done_n != 1 || got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
         miscompares++; $display("FAIL b2b_dump: got %0d words %0d done expected 2 1", got_q.size(), done_n);
      end
      random_words(2);
      build_range(20, 21);
      run_op(1'b1, 20, 21, 100, -1, 0);
      apply_load_model(hs_t.size());
      vectors++;
      if (busy0 !== 1'b1 || done_n != 1 || wlog.size() != 2 || rf[20] !== exp_rf[20] || rf[21] !== exp_rf[21]) begin
         miscompares++;
         $display("FAIL b2b_load: got busy0=%b done=%0d writes=%0d expected 1 1 2", busy0, done_n, wlog.size());
      end
   endtask

   task automatic test_random();
      int f, l, m, p;
      for (int it = 0; it < 10; it++) begin
         m = $urandom_range(1); f = $urandom_range(31); l = $urandom_range(31); p = $urandom_range(100, 30);
         build_range(f, l);
         if (m == 0) begin
            run_op(1'b0, f, l, p, -1, 0);
            vectors++;
            if (done_n != 1 || got_q.size() != exp_q.size()) begin
               miscompares++;
               $display("FAIL rnd_dump %0d..%0d: got %0d words %0d done expected %0d 1",
                        f, l, got_q.size(), done_n, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
               vectors++;
               if (got_q[i] !== exp_q[i]) begin
                  miscompares++; $display("FAIL rnd_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
               end
            end
         end else begin
            random_words(exp_idx.size());
            run_op(1'b1, f, l, p, -1, 0);
            apply_load_model(hs_t.size());
            vectors++;
            if (done_n != 1 || wlog.size() != exp_wr.size() || hs_t.size() != exp_idx.size()) begin
               miscompares++;
               $display("FAIL rnd_load %0d..%0d: got %0d writes %0d done expected %0d 1",
                        f, l, wlog.size(), done_n, exp_wr.size());
            end
            for (int j = 0; j < exp_wr.size() && j < wlog.size(); j++) begin
               vectors++;
               if (wlog[j].t != exp_wr[j].t || wlog[j].a !== exp_wr[j].a || wlog[j].d !== exp_wr[j].d) begin
                  miscompares++;
                  $display("FAIL rnd_write[%0d]: got t=%0d x%0d=%h expected t=%0d x%0d=%h", j,
                           wlog[j].t, wlog[j].a, wlog[j].d, exp_wr[j].t, exp_wr[j].a, exp_wr[j].d);
               end
            end
            for (int i = 1; i < 32; i++) begin
               if (rf[i] !== exp_rf[i]) begin
                  vectors++; miscompares++;
                  $display("FAIL rnd_reg x%0d: got %h expected %h", i, rf[i], exp_rf[i]);
               end
            end
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_dump_wrap();
      test_dump_backpressure();
      test_load_range();
      test_full_sweep();
      test_abort();
      test_reset_mid_dump();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
